ps2_keypad_rx: RTL

//  PS/2 device-to-host receiver: the chip8 machine's end of the ps2_clk/ps2_data keyboard stream from user_io.
//  - Deserialises 11-bit frames and decodes set-2 make/break/E0 prefixes.
//  - Presents decoded scan events and a live 16-key Chip-8 hex keypad state for the CPU's SKP/SKNP/LD Vx,K opcodes.

---
 rtl/ps2_keypad_rx_pkg.sv | 66 ++++++
 rtl/ps2_keypad_rx_frame.sv | 125 ++++++++++++
 rtl/ps2_keypad_rx.sv | 136 +++++++++++++
 3 files changed

// File: rtl/ps2_keypad_rx_pkg.sv
// Shared constants, event types and the keypad scan-code map for the PS/2 keypad receiver.
package ps2_keypad_rx_pkg;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  localparam logic [7:0] PS2_KEY_0 = 8'h22;
  localparam logic [7:0] PS2_KEY_1 = 8'h16;
  localparam logic [7:0] PS2_KEY_2 = 8'h1E;
  localparam logic [7:0] PS2_KEY_3 = 8'h26;
  localparam logic [7:0] PS2_KEY_4 = 8'h15;
  localparam logic [7:0] PS2_KEY_5 = 8'h1D;
  localparam logic [7:0] PS2_KEY_6 = 8'h24;
  localparam logic [7:0] PS2_KEY_7 = 8'h1C;
  localparam logic [7:0] PS2_KEY_8 = 8'h1B;
  localparam logic [7:0] PS2_KEY_9 = 8'h23;
  localparam logic [7:0] PS2_KEY_A = 8'h1A;
  localparam logic [7:0] PS2_KEY_B = 8'h21;
  localparam logic [7:0] PS2_KEY_C = 8'h25;
  localparam logic [7:0] PS2_KEY_D = 8'h2D;
  localparam logic [7:0] PS2_KEY_E = 8'h2B;
  localparam logic [7:0] PS2_KEY_F = 8'h2A;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  typedef struct packed {
    logic [7:0] code;
    logic       brk;
    logic       ext;
  } ps2_event_t;

  typedef struct packed {
    logic       hit;
    logic [3:0] idx;
  } key_map_t;

  function automatic key_map_t map_key(input logic [7:0] code);
    key_map_t m;
    m.hit = 1'b1;
    m.idx = 4'h0;
    case (code)
      PS2_KEY_0: m.idx = 4'h0;
      PS2_KEY_1: m.idx = 4'h1;
      PS2_KEY_2: m.idx = 4'h2;
      PS2_KEY_3: m.idx = 4'h3;
      PS2_KEY_4: m.idx = 4'h4;
      PS2_KEY_5: m.idx = 4'h5;
      PS2_KEY_6: m.idx = 4'h6;
      PS2_KEY_7: m.idx = 4'h7;
      PS2_KEY_8: m.idx = 4'h8;
      PS2_KEY_9: m.idx = 4'h9;
      PS2_KEY_A: m.idx = 4'hA;
      PS2_KEY_B: m.idx = 4'hB;
      PS2_KEY_C: m.idx = 4'hC;
      PS2_KEY_D: m.idx = 4'hD;
      PS2_KEY_E: m.idx = 4'hE;
      PS2_KEY_F: m.idx = 4'hF;
      default:   m.hit = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ps2_keypad_rx_frame.sv
// PS/2 frame receiver: input synchronisers, ps2_clk glitch filter, 11-bit frame FSM and inter-bit timeout.
module ps2_frame_rx
  import ps2_keypad_rx_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       res,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_strobe,
  output logic       frame_err
);

  localparam int unsigned FILT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]        clk_sync_q, data_sync_q;
  logic              filt_q, filt_d;
  logic [FILT_W-1:0] filt_cnt_q, filt_cnt_d;
  logic [1:0]        state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              par_q, par_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              strobe_q, strobe_d;
  logic              err_q, err_d;
  logic              fall;
  logic              data_s;

  assign data_s = data_sync_q[1];

  // A level change is accepted only after FILTER_LEN consecutive samples disagree with the filtered level.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    filt_d     = filt_q;
    filt_cnt_d = '0;
    if (clk_sync_q[1] != filt_q) begin
      if (filt_cnt_q == FILT_W'(FILTER_LEN - 1)) begin
        filt_d = clk_sync_q[1];
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  assign fall = filt_q & ~filt_d;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    tmo_d     = '0;
    strobe_d  = 1'b0;
    err_d     = 1'b0;
    if (fall) begin
      case (state_q)
        ST_IDLE: begin
          if (!data_s) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end
        end
        ST_DATA: begin
          shift_d   = {data_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          par_d   = data_s;
          state_d = ST_STOP;
        end
        default: begin
          if (data_s && (^{shift_q, par_q})) strobe_d = 1'b1;
          else                               err_d    = 1'b1;
          state_d = ST_IDLE;
        end
      endcase
    end else if (state_q != ST_IDLE) begin
      if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
        state_d = ST_IDLE;
        err_d   = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (res) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filt_q      <= 1'b1;
      filt_cnt_q  <= '0;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      tmo_q       <= '0;
      strobe_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
      filt_q      <= filt_d;
      filt_cnt_q  <= filt_cnt_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      tmo_q       <= tmo_d;
      strobe_q    <= strobe_d;
      err_q       <= err_d;
    end
  end

  assign rx_byte     = shift_q;
  assign byte_strobe = strobe_q;
  assign frame_err   = err_q;

endmodule

// File: rtl/ps2_keypad_rx.sv
// PS/2 keyboard receiver for the Chip-8 keypad: set-2 prefix decoding, 16-key state and event output.
// Define PS2_KEYPAD_FIFO_EN to queue events in a FIFO_DEPTH FIFO instead of a single holding register.
module ps2_keypad_rx
  import ps2_keypad_rx_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        res,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic        ev_valid,
  output logic [7:0]  ev_code,
  output logic        ev_break,
  output logic        ev_ext,
  input  logic        ev_ack,
  output logic [15:0] keys,
  output logic        frame_err
);

  logic [7:0]  rx_byte;
  logic        byte_strobe;
  logic        ext_q, ext_d, brk_q, brk_d;
  logic        push;
  ps2_event_t  new_ev, head;
  logic [15:0] keys_q, keys_d;
  key_map_t    km;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .FILTER_LEN    (FILTER_LEN)
  ) u_frame (
    .clk        (clk),
    .res        (res),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rx_byte    (rx_byte),
    .byte_strobe(byte_strobe),
    .frame_err  (frame_err)
  );

  assign km     = map_key(rx_byte);
  assign new_ev = '{code: rx_byte, brk: brk_q, ext: ext_q};

  always_comb begin
    ext_d  = ext_q;
    brk_d  = brk_q;
    keys_d = keys_q;
    push   = 1'b0;
    if (frame_err) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_strobe) begin
      if (rx_byte == PS2_PREFIX_EXT) begin
        ext_d = 1'b1;
      end else if (rx_byte == PS2_PREFIX_BRK) begin
        brk_d = 1'b1;
      end else begin
        push  = 1'b1;
        ext_d = 1'b0;
        brk_d = 1'b0;
        if (!ext_q && km.hit) keys_d[km.idx] = ~brk_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      ext_q  <= 1'b0;
      brk_q  <= 1'b0;
      keys_q <= '0;
    end else begin
      ext_q  <= ext_d;
      brk_q  <= brk_d;
      keys_q <= keys_d;
    end
  end

`ifdef PS2_KEYPAD_FIFO_EN
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  ps2_event_t mem_q [FIFO_DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic        empty, full, pop, do_push;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop     = ev_ack && !empty;
  // A full FIFO still accepts a push when the head is popped in the same cycle.
  assign do_push = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (res) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (pop)     rd_q <= rd_q + 1'b1;
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= new_ev;
  end

  assign ev_valid = !empty;
  assign head     = empty ? '0 : mem_q[rd_q[AW-1:0]];
`else
  ps2_event_t hold_q;
  logic       valid_q;

  always_ff @(posedge clk) begin
    if (res) begin
      hold_q  <= '0;
      valid_q <= 1'b0;
    end else if (push) begin
      hold_q  <= new_ev;
      valid_q <= 1'b1;
    end else if (ev_ack && valid_q) begin
      valid_q <= 1'b0;
    end
  end

  assign ev_valid = valid_q;
  assign head     = hold_q;
`endif

  assign ev_code  = head.code;
  assign ev_break = head.brk;
  assign ev_ext   = head.ext;
  assign keys     = keys_q;

endmodule
